frb_sample_player: RTL and testbench
====================================

// Module: frb_sample_player
// PURPOSE
//  Downstream consumer of the synthetic-FRB address counter. Owns the pulse-shape sample RAM and arms the counter via en.
//  Reads one sample per addr_valid pulse, scales it by a run-time gain, saturates it and streams it to the injection adder.
//  Sequences one playback per trigger, then drops en so the counter rewinds.
// PARAMETERS
//  ADDR_SIZE   8   sample RAM address width (depth 2**ADDR_SIZE), equal to the counter's ADDR_SIZE
//  DIN_WIDTH   16  stored sample width, signed
//  GAIN_WIDTH  16  gain width, unsigned
//  GAIN_POINT  15  fractional bits of gain (GAIN_POINT=15 -> 0x8000 = 1.0)
//  DOUT_WIDTH  16  output sample width, signed, saturated
// PORTS
//  clk         in   1           single clock domain for everything
//  rst         in   1           synchronous, active-high reset
//  wr_en       in   1           sample RAM write strobe (config side)
//  wr_addr     in   ADDR_SIZE   sample RAM write address
//  wr_data     in   DIN_WIDTH   sample RAM write data
//  gain        in   GAIN_WIDTH  amplitude scale; captured when a trigger is accepted
//  trigger     in   1           start request, sampled high for one cycle
//  abort       in   1           stop playback now
//  en          out  1           enable to the address counter
//  addr        in   ADDR_SIZE   read address from the counter
//  addr_valid  in   1           read strobe from the counter
//  finish      in   1           counter has reached its last address
//  dout        out  DOUT_WIDTH  scaled sample
//  dout_valid  out  1           dout qualifier, one per addr_valid
//  busy        out  1           high in PLAY and DRAIN
//  done        out  1           one-cycle pulse when a playback completes or is aborted
// BEHAVIOUR
//  Reset: FSM=IDLE; en, dout, dout_valid, busy, done = 0; pipeline valids cleared; gain register = 0.
//  RAM contents are not cleared by rst.
//  FSM states: IDLE, PLAY, DRAIN, DONE.
//   IDLE : trigger=1 -> PLAY, gain_r<=gain. Trigger and abort in the same cycle: abort wins, stay IDLE.
//   PLAY : en=1. finish=1 -> DRAIN. abort=1 -> DONE, valids flushed. Triggers are ignored.
//   DRAIN: en=1. Counts 3 cycles so the pipeline empties -> DONE. abort=1 -> DONE, valids flushed.
//   DONE : en=0 for exactly 1 cycle (the counter rewinds on the en falling edge); done=1 -> IDLE.
//  busy = (state==PLAY || state==DRAIN).
//  Pipeline: fixed latency of 3 cycles from addr_valid to dout_valid, no backpressure.
//   c1: RAM registered read at addr.
//   c2: signed product sample * $signed({1'b0,gain_r}), width DIN_WIDTH+GAIN_WIDTH+1.
//   c3: arithmetic right shift by GAIN_POINT (truncate toward -inf), saturate to DOUT_WIDTH signed.
//  addr_valid is honoured only in PLAY or DRAIN; otherwise it is dropped.
//  dout holds its last value when dout_valid=0. Abort clears dout_valid but not dout.
//  RAM is read-first: a same-cycle write and read to one address returns the old data. Writes are allowed in any state.
//  Saturation: results > 2**(DOUT_WIDTH-1)-1 clip to max; results < -2**(DOUT_WIDTH-1) clip to min.
//  rst mid-operation: immediate return to IDLE, en drops, in-flight samples are discarded and no done pulse is issued.
// STRUCTURE
//  Shared package frb_pkg: FSM state enum, DRAIN_CYCLES=3, and saturation limits as functions of DOUT_WIDTH.
//  One sub-module: frb_sample_ram (simple dual-port, registered read-first read). FSM and scaler stay in this module.
// TESTING
//  1. Load RAM[i]=i*16. gain=0x8000, trigger, counter with decimate=0.
//     -> dout = addr*16, dout_valid 3 cycles after each addr_valid, done pulse after DRAIN, en low 1 cycle.
//  2. RAM[5]=0x7000, gain=0x10000 (2.0, needs GAIN_WIDTH=17 build) -> dout=0x7FFF. RAM[5]=0x9000 -> dout=0x8000 (saturated).
//  3. RAM[3]=-3, gain=0x4000 (0.5) -> dout=-2 (floor). RAM[3]=3 -> dout=1.
//  4. abort mid-PLAY at addr 40 -> no dout_valid afterwards, done=1 the next cycle, en=0 one cycle.
//     New trigger -> addresses restart from the counter's first value.
//  5. trigger repeated during PLAY -> ignored, one done only. trigger+abort same cycle in IDLE -> stays IDLE.
//  6. rst asserted in DRAIN -> en=0, dout_valid=0, done=0 next cycle. RAM data survives (replay matches scenario 1).

Source files
------------

// File: rtl/frb_pkg.sv
// Shared types and constants for the synthetic-FRB sample player.
package frb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int DRAIN_CYCLES = 3;

  function automatic longint sat_max(input int width);
    return (longint'(1) <<< (width - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/frb_sample_ram.sv
// Simple dual-port pulse-shape RAM with registered, read-first read port.
module frb_sample_ram #(
  parameter int ADDR_SIZE  = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_SIZE-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_SIZE-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_SIZE];

  // Non-blocking update of mem gives old data on a same-address collision.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/frb_sample_player.sv
// Plays one stored FRB pulse per trigger: RAM read, gain scale, saturate, stream out.
//
//   state | meaning
//   IDLE  | waiting for trigger, counter held off
//   PLAY  | counter enabled, samples accepted until finish
//   DRAIN | counter still enabled, pipeline emptying
//   DONE  | en low one cycle so the counter rewinds, done pulse
module frb_sample_player
  import frb_pkg::*;
#(
  parameter int ADDR_SIZE  = 8,
  parameter int DIN_WIDTH  = 16,
  parameter int GAIN_WIDTH = 16,
  parameter int GAIN_POINT = 15,
  parameter int DOUT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [ADDR_SIZE-1:0]         wr_addr,
  input  logic [DIN_WIDTH-1:0]         wr_data,
  input  logic [GAIN_WIDTH-1:0]        gain,
  input  logic                         trigger,
  input  logic                         abort,
  output logic                         en,
  input  logic [ADDR_SIZE-1:0]         addr,
  input  logic                         addr_valid,
  input  logic                         finish,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         dout_valid,
  output logic                         busy,
  output logic                         done
);

  localparam int PROD_WIDTH = DIN_WIDTH + GAIN_WIDTH + 1;
  localparam int CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic signed [PROD_WIDTH-1:0] SAT_HI = PROD_WIDTH'(sat_max(DOUT_WIDTH));
  localparam logic signed [PROD_WIDTH-1:0] SAT_LO = PROD_WIDTH'(sat_min(DOUT_WIDTH));

  state_t                         state, state_nxt;
  logic [CNT_W-1:0]               drain_cnt;
  logic [GAIN_WIDTH-1:0]          gain_r;
  logic                           load_gain;
  logic                           flush;
  logic                           accept;
  logic [DIN_WIDTH-1:0]           rd_data;
  logic                           v1, v2;
  logic signed [PROD_WIDTH-1:0]   prod;
  logic signed [PROD_WIDTH-1:0]   shifted;
  logic signed [DOUT_WIDTH-1:0]   sat_val;

  always_comb begin
    state_nxt = state;
    load_gain = 1'b0;
    flush     = 1'b0;
    case (state)
      ST_IDLE: begin
        // abort in the same cycle cancels the request
        if (trigger && !abort) begin
          state_nxt = ST_PLAY;
          load_gain = 1'b1;
        end
      end
      ST_PLAY: begin
        if (abort) begin
          state_nxt = ST_DONE;
          flush     = 1'b1;
        end else if (finish) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_nxt = ST_DONE;
          flush     = 1'b1;
        end else if (drain_cnt == '0) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign busy   = (state == ST_PLAY) || (state == ST_DRAIN);
  assign en     = busy;
  assign done   = (state == ST_DONE);
  assign accept = addr_valid && busy && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
      gain_r    <= '0;
    end else begin
      state <= state_nxt;
      if (load_gain) gain_r <= gain;
      // terminal count at zero ends DRAIN; reloaded every PLAY cycle
      if (state == ST_PLAY)       drain_cnt <= DRAIN_LOAD;
      else if (state == ST_DRAIN) drain_cnt <= drain_cnt - 1'b1;
    end
  end

  frb_sample_ram #(
    .ADDR_SIZE  (ADDR_SIZE),
    .DATA_WIDTH (DIN_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (accept),
    .rd_addr (addr),
    .rd_data (rd_data)
  );

  always_comb begin
    shifted = prod >>> GAIN_POINT;
    if (shifted > SAT_HI)      sat_val = SAT_HI[DOUT_WIDTH-1:0];
    else if (shifted < SAT_LO) sat_val = SAT_LO[DOUT_WIDTH-1:0];
    else                       sat_val = shifted[DOUT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      prod       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      v1         <= accept;
      v2         <= v1 && !flush;
      dout_valid <= v2 && !flush;
      if (v1) begin
        prod <= PROD_WIDTH'($signed(rd_data)) * PROD_WIDTH'($signed({1'b0, gain_r}));
      end
      if (v2 && !flush) dout <= sat_val;
    end
  end

endmodule

// File: tb/tb_frb_sample_player.sv
// Directed bench for frb_sample_player with a behavioural address counter (decimate=0).
module tb_frb_sample_player;

  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int GW   = 17;
  localparam int GP   = 15;
  localparam int OW   = 16;
  localparam int LAST = 63;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [GW-1:0] gain = '0;
  logic          trigger = 1'b0;
  logic          abort = 1'b0;
  logic          en;
  logic [AW-1:0] addr = '0;
  logic          addr_valid = 1'b0;
  logic          finish = 1'b0;
  logic [OW-1:0] dout;
  logic          dout_valid;
  logic          busy;
  logic          done;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  frb_sample_player #(
    .ADDR_SIZE  (AW),
    .DIN_WIDTH  (DW),
    .GAIN_WIDTH (GW),
    .GAIN_POINT (GP),
    .DOUT_WIDTH (OW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .gain       (gain),
    .trigger    (trigger),
    .abort      (abort),
    .en         (en),
    .addr       (addr),
    .addr_valid (addr_valid),
    .finish     (finish),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] scale(input logic [15:0] s, input logic [GW-1:0] g);
    longint p;
    p = longint'($signed(s)) * longint'(g);
    p = p >>> GP;
    if (p > 32767)       p = 32767;
    else if (p < -32768) p = -32768;
    return p[15:0];
  endfunction

  logic [15:0]   ram_img [256];
  logic [15:0]   out_by_addr [256];
  bit            hv [8];
  logic [AW-1:0] ha [8];
  logic [15:0]   he [8];
  int            cyc = 0;
  int            cnt = 0;
  bit            stopped = 1'b0;
  bit            fin_pending = 1'b0;
  int            fin_cyc = 0;
  int            n_valid = 0;
  int            n_done = 0;

  // Monitor first, then the counter model; one process keeps the ordering fixed.
  always @(negedge clk) begin
    int idx;
    idx = (cyc - 3) & 7;
    if (dout_valid) begin
      n_valid++;
      chk("latency", hv[idx], 1);
      chk("dout", dout, he[idx]);
      out_by_addr[ha[idx]] = dout;
    end
    if (done) begin
      n_done++;
      if (fin_pending) begin
        chk("finish_to_done", cyc - fin_cyc, 4);
        fin_pending = 1'b0;
      end
    end
    if (!en) begin
      cnt = 0; stopped = 1'b0; addr_valid = 1'b0; finish = 1'b0; fin_pending = 1'b0;
    end else if (!stopped) begin
      addr = AW'(cnt);
      addr_valid = 1'b1;
      finish = (cnt == LAST);
      if (cnt == LAST) begin
        stopped = 1'b1; fin_pending = 1'b1; fin_cyc = cyc;
      end
      cnt++;
    end else begin
      addr_valid = 1'b0; finish = 1'b0;
    end
    hv[cyc & 7] = addr_valid;
    ha[cyc & 7] = addr;
    he[cyc & 7] = scale(ram_img[addr], gain);
    cyc++;
  end

  task automatic start(input logic [GW-1:0] g);
    @(negedge clk);
    gain = g; n_valid = 0; n_done = 0; trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_en", en, 1);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_en_low"}, en, 0);
    chk({tag, "_busy_low"}, busy, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    repeat (5) @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d; ram_img[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_en", en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dv", dout_valid, 0);
    chk("rst_dout", dout, 0);
    rst = 1'b0;

    for (int i = 0; i <= LAST; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = 16'(i * 16); ram_img[i] = 16'(i * 16);
    end
    @(negedge clk);
    wr_en = 1'b0;

    // unity gain playback with a stray trigger mid-PLAY
    start(17'h08000);
    repeat (20) @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    wait_done("run1");
    chk("run1_valids", n_valid, 64);
    chk("run1_ndone", n_done, 1);
    chk("run1_a37", out_by_addr[37], 16'd592);
    chk("run1_a63", out_by_addr[63], 16'd1008);

    // trigger and abort together in IDLE
    @(negedge clk);
    trigger = 1'b1; abort = 1'b1;
    @(negedge clk);
    trigger = 1'b0; abort = 1'b0;
    chk("trig_abort_busy", busy, 0);
    chk("trig_abort_en", en, 0);

    // abort while addr 40 is presented
    start(17'h08000);
    repeat (40) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_done", done, 1);
    chk("abort_en", en, 0);
    chk("abort_dv", dout_valid, 0);
    repeat (10) @(negedge clk);
    chk("abort_valids", n_valid, 38);
    chk("abort_ndone", n_done, 1);

    start(17'h08000);
    wait_done("replay1");
    chk("replay1_valids", n_valid, 64);

    // reset during DRAIN
    start(17'h08000);
    repeat (64) @(negedge clk);
    chk("drain_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstd_en", en, 0);
    chk("rstd_dv", dout_valid, 0);
    chk("rstd_done", done, 0);
    chk("rstd_busy", busy, 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rstd_ndone", n_done, 0);
    chk("rstd_valids", n_valid, 62);

    start(17'h08000);
    wait_done("replay2");
    chk("replay2_valids", n_valid, 64);
    chk("replay2_a63", out_by_addr[63], 16'd1008);

    // gain 2.0 with saturation both ways
    wr(5, 16'h7000);
    wr(6, 16'h9000);
    start(17'h10000);
    wait_done("sat");
    chk("sat_pos", out_by_addr[5], 16'h7FFF);
    chk("sat_neg", out_by_addr[6], 16'h8000);
    chk("sat_a7", out_by_addr[7], 16'd224);

    // gain 0.5 flooring, plus a read-first collision at addr 10
    wr(3, 16'hFFFD);
    wr(4, 16'h0003);
    start(17'h04000);
    repeat (10) @(negedge clk);
    wr_en = 1'b1; wr_addr = 8'd10; wr_data = 16'h1234;
    @(negedge clk);
    wr_en = 1'b0; ram_img[10] = 16'h1234;
    wait_done("half");
    chk("half_neg3", out_by_addr[3], 16'hFFFE);
    chk("half_pos3", out_by_addr[4], 16'h0001);
    chk("half_rf_a10", out_by_addr[10], 16'd80);
    chk("half_a20", out_by_addr[20], 16'd160);

    start(17'h08000);
    wait_done("final");
    chk("final_a10", out_by_addr[10], 16'h1234);
    chk("final_a3", out_by_addr[3], 16'hFFFD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
